decode_execute_buffer: RTL and testbench

Pipeline register between the decode-stage control unit and the execute stage. Latches the control bundle, operands, PC and multi-cycle sequencing state (LDM St/Sst, flush count, CALL/RET/INT phase) every cycle. The sequencing state is fed back to the control unit as its *In inputs. Also captures external interrupt requests and presents `interruptSignal` to the control unit only at a safe instruction boundary.

---
 rtl/decode_execute_buffer_pkg.sv | 38 +++
 rtl/decode_execute_buffer_int_capture.sv | 66 ++++++
 rtl/decode_execute_buffer.sv | 176 +++++++++++++++++
 tb/tb_decode_execute_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_execute_buffer_pkg.sv
// Shared constants for the decode/execute pipeline buffer: ALU opcodes,
// control-bundle width, and the multi-cycle phase encodings used by
// the CALL/RET/INT sequencing in the control unit.
package decode_execute_buffer_pkg;

  localparam int CTRL_W = 10;
  localparam int ALU_W  = 5;
  localparam int FT_W   = 2;

  // Phase encoding of the firstTime* sequencing fields
  localparam logic [FT_W-1:0] FT_IDLE   = 2'b00;
  localparam logic [FT_W-1:0] FT_SECOND = 2'b01;
  localparam logic [FT_W-1:0] FT_FIRST  = 2'b11;

  // ALU operation codes; NOP is non-zero so a bubble is distinguishable
  // from an all-zero bundle
  localparam logic [ALU_W-1:0] ALU_ADD = 5'h01;
  localparam logic [ALU_W-1:0] ALU_SUB = 5'h02;
  localparam logic [ALU_W-1:0] ALU_AND = 5'h03;
  localparam logic [ALU_W-1:0] ALU_OR  = 5'h04;
  localparam logic [ALU_W-1:0] ALU_NOT = 5'h05;
  localparam logic [ALU_W-1:0] ALU_INC = 5'h06;
  localparam logic [ALU_W-1:0] ALU_DEC = 5'h07;
  localparam logic [ALU_W-1:0] ALU_SHL = 5'h08;
  localparam logic [ALU_W-1:0] ALU_SHR = 5'h09;
  localparam logic [ALU_W-1:0] ALU_MOV = 5'h0A;
  localparam logic [ALU_W-1:0] ALU_NOP = 5'h1F;

  // Control bundle of a register-register ALU instruction:
  // {IR,IW,MR,MW,MTR,ALU_src,RW,Branch,SetC,CLRC} with RW and SetC set
  localparam logic [CTRL_W-1:0] ALU_SIGNALS = 10'b00_0000_1010;

  // True while a CALL/RET/INT sequence sits in its first phase
  function automatic logic ft_in_first(input logic [FT_W-1:0] ft);
    return (ft == FT_FIRST);
  endfunction

endpackage

// File: rtl/decode_execute_buffer_int_capture.sv
// Interrupt capture for the decode/execute buffer. Detects the rising
// edge of the external request, keeps a pending flag until the control
// unit starts the INT sequence, and only presents the interrupt at an
// instruction boundary (no LDM/CALL/RET/INT/flush sequence in flight,
// no stall or flush this cycle).
module decode_execute_buffer_int_capture
  import decode_execute_buffer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_int_req,
  input  logic            i_load,
  input  logic [FT_W-1:0] i_ftint_in,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_st,
  input  logic            i_sst,
  input  logic [FT_W-1:0] i_ftcall,
  input  logic [FT_W-1:0] i_ftret,
  input  logic [FT_W-1:0] i_ftint,
  input  logic [1:0]      i_flush_num,
  output logic            o_int_signal
);

  logic r_int_req_q;
  logic r_int_pending;
  logic w_set;
  logic w_clear;
  logic w_busy;

  // A new request is its rising edge; the INT sequence being loaded
  // consumes it. A set on the same edge wins so a back-to-back request
  // is not lost.
  assign w_set   = i_int_req & ~r_int_req_q;
  assign w_clear = i_load & (i_ftint_in == FT_FIRST);

  // Edge-detect register and pending flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_req_q   <= 1'b0;
      r_int_pending <= 1'b0;
    end else begin
      r_int_req_q <= i_int_req;
      if (w_set) begin
        r_int_pending <= 1'b1;
      end else if (w_clear) begin
        r_int_pending <= 1'b0;
      end
    end
  end

  // Boundary gating: the INT sequence blocks until its phase returns to
  // idle so a second request is never presented mid-INT
  always_comb begin
    w_busy = 1'b0;
    if (i_st & i_sst)                 w_busy = 1'b1;
    if (ft_in_first(i_ftcall))        w_busy = 1'b1;
    if (ft_in_first(i_ftret))         w_busy = 1'b1;
    if (i_ftint != FT_IDLE)           w_busy = 1'b1;
    if (i_flush_num != 2'b00)         w_busy = 1'b1;
    if (i_stall | i_flush)            w_busy = 1'b1;
  end

  assign o_int_signal = r_int_pending & ~w_busy;

endmodule

// File: rtl/decode_execute_buffer.sv
// Decode -> execute pipeline register. Latches the control bundle,
// operands, PC and the multi-cycle sequencing state each cycle; a flush
// loads a bubble (control and sequencing cleared, data still loaded) and
// a stall holds everything. Interrupt presentation lives in the
// int_capture sub-module.
module decode_execute_buffer
  import decode_execute_buffer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              int_req_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [ALU_W-1:0]  alu_sig_i,
  input  logic              shift_i,
  input  logic              isPush_i,
  input  logic [1:0]        push_pop_i,
  input  logic              st_i,
  input  logic              sst_i,
  input  logic [1:0]        flush_num_i,
  input  logic [FT_W-1:0]   ftcall_i,
  input  logic [FT_W-1:0]   ftret_i,
  input  logic [FT_W-1:0]   ftint_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] rsrc_data_i,
  input  logic [DATA_W-1:0] rdst_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] rsrc_addr_i,
  input  logic [REG_AW-1:0] rdst_addr_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [ALU_W-1:0]  alu_sig_o,
  output logic              shift_o,
  output logic              isPush_o,
  output logic [1:0]        push_pop_o,
  output logic              st_o,
  output logic              sst_o,
  output logic [1:0]        flush_num_o,
  output logic [FT_W-1:0]   ftcall_o,
  output logic [FT_W-1:0]   ftret_o,
  output logic [FT_W-1:0]   ftint_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] rsrc_data_o,
  output logic [DATA_W-1:0] rdst_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [REG_AW-1:0] rsrc_addr_o,
  output logic [REG_AW-1:0] rdst_addr_o,
  output logic              interruptSignal_o
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [ALU_W-1:0]  r_alu_sig;
  logic              r_shift;
  logic              r_is_push;
  logic [1:0]        r_push_pop;
  logic              r_st;
  logic              r_sst;
  logic [1:0]        r_flush_num;
  logic [FT_W-1:0]   r_ftcall;
  logic [FT_W-1:0]   r_ftret;
  logic [FT_W-1:0]   r_ftint;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_rsrc_data;
  logic [DATA_W-1:0] r_rdst_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rsrc_addr;
  logic [REG_AW-1:0] r_rdst_addr;

  logic w_load;
  logic w_take_data;

  // A normal load happens when neither flush nor stall wins this edge;
  // data fields are also taken on a flush since the bubble keeps them
  assign w_load      = ~flush_i & ~stall_i;
  assign w_take_data = flush_i | ~stall_i;

  // Control and sequencing fields: reset > flush (bubble) > stall > load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl      <= '0;
      r_alu_sig   <= ALU_NOP;
      r_shift     <= 1'b0;
      r_is_push   <= 1'b0;
      r_push_pop  <= '0;
      r_st        <= 1'b0;
      r_sst       <= 1'b0;
      r_flush_num <= '0;
      r_ftcall    <= FT_IDLE;
      r_ftret     <= FT_IDLE;
      r_ftint     <= FT_IDLE;
    end else if (flush_i) begin
      r_ctrl      <= '0;
      r_alu_sig   <= ALU_NOP;
      r_shift     <= 1'b0;
      r_is_push   <= 1'b0;
      r_push_pop  <= '0;
      r_st        <= 1'b0;
      r_sst       <= 1'b0;
      r_flush_num <= '0;
      r_ftcall    <= FT_IDLE;
      r_ftret     <= FT_IDLE;
      r_ftint     <= FT_IDLE;
    end else if (w_load) begin
      r_ctrl      <= ctrl_i;
      r_alu_sig   <= alu_sig_i;
      r_shift     <= shift_i;
      r_is_push   <= isPush_i;
      r_push_pop  <= push_pop_i;
      r_st        <= st_i;
      r_sst       <= sst_i;
      r_flush_num <= flush_num_i;
      r_ftcall    <= ftcall_i;
      r_ftret     <= ftret_i;
      r_ftint     <= ftint_i;
    end
  end

  // PC, operands and register addresses: loaded on both load and flush
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= '0;
      r_rsrc_data <= '0;
      r_rdst_data <= '0;
      r_imm       <= '0;
      r_rsrc_addr <= '0;
      r_rdst_addr <= '0;
    end else if (w_take_data) begin
      r_pc        <= pc_i;
      r_rsrc_data <= rsrc_data_i;
      r_rdst_data <= rdst_data_i;
      r_imm       <= imm_i;
      r_rsrc_addr <= rsrc_addr_i;
      r_rdst_addr <= rdst_addr_i;
    end
  end

  assign ctrl_o      = r_ctrl;
  assign alu_sig_o   = r_alu_sig;
  assign shift_o     = r_shift;
  assign isPush_o    = r_is_push;
  assign push_pop_o  = r_push_pop;
  assign st_o        = r_st;
  assign sst_o       = r_sst;
  assign flush_num_o = r_flush_num;
  assign ftcall_o    = r_ftcall;
  assign ftret_o     = r_ftret;
  assign ftint_o     = r_ftint;
  assign pc_o        = r_pc;
  assign rsrc_data_o = r_rsrc_data;
  assign rdst_data_o = r_rdst_data;
  assign imm_o       = r_imm;
  assign rsrc_addr_o = r_rsrc_addr;
  assign rdst_addr_o = r_rdst_addr;

  decode_execute_buffer_int_capture u_int_capture (
    .clk          (clk),
    .rst          (rst),
    .i_int_req    (int_req_i),
    .i_load       (w_load),
    .i_ftint_in   (ftint_i),
    .i_stall      (stall_i),
    .i_flush      (flush_i),
    .i_st         (r_st),
    .i_sst        (r_sst),
    .i_ftcall     (r_ftcall),
    .i_ftret      (r_ftret),
    .i_ftint      (r_ftint),
    .i_flush_num  (r_flush_num),
    .o_int_signal (interruptSignal_o)
  );

endmodule

// File: tb/tb_decode_execute_buffer.sv
// Bench for decode_execute_buffer: directed scenarios with literal
// expectations plus a behavioural model compared every cycle.
module tb_decode_execute_buffer;
  import decode_execute_buffer_pkg::*;

  typedef struct packed {
    logic [9:0]  ctrl;
    logic [4:0]  alu;
    logic        shift;
    logic        is_push;
    logic [1:0]  push_pop;
    logic        st;
    logic        sst;
    logic [1:0]  flush_num;
    logic [1:0]  ftcall;
    logic [1:0]  ftret;
    logic [1:0]  ftint;
    logic [31:0] pc;
    logic [15:0] rsrc_data;
    logic [15:0] rdst_data;
    logic [15:0] imm;
    logic [2:0]  rsrc_addr;
    logic [2:0]  rdst_addr;
  } bundle_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic    stall_i, flush_i, int_req_i;
  bundle_t d;

  logic [9:0]  ctrl_o;
  logic [4:0]  alu_sig_o;
  logic        shift_o, isPush_o, st_o, sst_o, interruptSignal_o;
  logic [1:0]  push_pop_o, flush_num_o, ftcall_o, ftret_o, ftint_o;
  logic [31:0] pc_o;
  logic [15:0] rsrc_data_o, rdst_data_o, imm_o;
  logic [2:0]  rsrc_addr_o, rdst_addr_o;

  decode_execute_buffer dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .int_req_i(int_req_i),
    .ctrl_i(d.ctrl), .alu_sig_i(d.alu), .shift_i(d.shift), .isPush_i(d.is_push),
    .push_pop_i(d.push_pop), .st_i(d.st), .sst_i(d.sst), .flush_num_i(d.flush_num),
    .ftcall_i(d.ftcall), .ftret_i(d.ftret), .ftint_i(d.ftint), .pc_i(d.pc),
    .rsrc_data_i(d.rsrc_data), .rdst_data_i(d.rdst_data), .imm_i(d.imm),
    .rsrc_addr_i(d.rsrc_addr), .rdst_addr_i(d.rdst_addr),
    .ctrl_o(ctrl_o), .alu_sig_o(alu_sig_o), .shift_o(shift_o), .isPush_o(isPush_o),
    .push_pop_o(push_pop_o), .st_o(st_o), .sst_o(sst_o), .flush_num_o(flush_num_o),
    .ftcall_o(ftcall_o), .ftret_o(ftret_o), .ftint_o(ftint_o), .pc_o(pc_o),
    .rsrc_data_o(rsrc_data_o), .rdst_data_o(rdst_data_o), .imm_o(imm_o),
    .rsrc_addr_o(rsrc_addr_o), .rdst_addr_o(rdst_addr_o),
    .interruptSignal_o(interruptSignal_o)
  );

  bundle_t w_dut;
  assign w_dut = {ctrl_o, alu_sig_o, shift_o, isPush_o, push_pop_o, st_o, sst_o,
                  flush_num_o, ftcall_o, ftret_o, ftint_o, pc_o, rsrc_data_o,
                  rdst_data_o, imm_o, rsrc_addr_o, rdst_addr_o};

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Holds what the buffer must present: the last accepted bundle, with
  // a bubble replacing control/sequencing on a flush, plus a pending
  // interrupt flag driven by request edges and INT starts.
  bundle_t m;
  logic    m_pend;
  logic    m_req_prev;
  logic    m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m          = '0;
      m.alu      = ALU_NOP;
      m_pend     = 1'b0;
      m_req_prev = 1'b0;
      m_valid    = 1'b1;
    end else begin
      if (int_req_i && !m_req_prev)
        m_pend = 1'b1;
      else if (!flush_i && !stall_i && d.ftint == 2'b11)
        m_pend = 1'b0;
      m_req_prev = int_req_i;
      if (flush_i) begin
        m           = d;
        m.ctrl      = '0;
        m.alu       = ALU_NOP;
        m.shift     = 1'b0;
        m.is_push   = 1'b0;
        m.push_pop  = '0;
        m.st        = 1'b0;
        m.sst       = 1'b0;
        m.flush_num = '0;
        m.ftcall    = '0;
        m.ftret     = '0;
        m.ftint     = '0;
      end else if (!stall_i) begin
        m = d;
      end
    end
  end

  function automatic logic model_int();
    logic in_seq;
    in_seq = (m.st && m.sst) || m.ftcall == 2'b11 || m.ftret == 2'b11 ||
             m.ftint != 2'b00 || m.flush_num != 2'b00 || stall_i || flush_i;
    return m_pend && !in_seq;
  endfunction

  // Per-cycle compare, on the falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("bundle", 128'(w_dut), 128'(m));
      check("int_model", 128'(interruptSignal_o), 128'(model_int()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_idle();
    d       = '0;
    d.alu   = ALU_NOP;
    stall_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic finish_int_seq();
    d.ftint = FT_FIRST;  tick();
    d.ftint = FT_SECOND; tick();
    d.ftint = FT_IDLE;   tick();
  endtask

  logic [127:0] rv;

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; int_req_i = 1'b0;
    set_idle();
    tick(); tick();
    check("rst_alu", 128'(alu_sig_o), 128'(5'h1F));
    check("rst_ctrl", 128'(ctrl_o), 128'(0));
    check("rst_pc", 128'(pc_o), 128'(0));
    check("rst_int", 128'(interruptSignal_o), 128'(0));
    rst = 1'b0;

    // ADD bundle appears one cycle later
    d.ctrl = ALU_SIGNALS; d.alu = ALU_ADD; d.pc = 32'h10;
    d.rsrc_data = 16'h1234; d.rdst_data = 16'hABCD; d.imm = 16'h0042;
    d.rsrc_addr = 3'd3; d.rdst_addr = 3'd5;
    tick();
    check("load_ctrl", 128'(ctrl_o), 128'(10'h00A));
    check("load_alu", 128'(alu_sig_o), 128'(5'h01));
    check("load_pc", 128'(pc_o), 128'(32'h10));
    check("load_rdst", 128'(rdst_data_o), 128'(16'hABCD));
    check("load_addr", 128'(rdst_addr_o), 128'(3'd5));
    rst = 1'b1; tick();
    check("rst2_alu", 128'(alu_sig_o), 128'(5'h1F));
    check("rst2_pc", 128'(pc_o), 128'(0));
    rst = 1'b0;

    // Stall freezes, flush+stall loads a bubble with the new PC
    d.pc = 32'h20; tick();
    check("pre_stall_pc", 128'(pc_o), 128'(32'h20));
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d.pc = 32'h24 + 32'(4 * i); d.ctrl = 10'h3FF; d.alu = ALU_SUB;
      tick();
      check("stall_pc", 128'(pc_o), 128'(32'h20));
      check("stall_ctrl", 128'(ctrl_o), 128'(10'h00A));
    end
    flush_i = 1'b1; d.pc = 32'h30; tick();
    check("flush_ctrl", 128'(ctrl_o), 128'(0));
    check("flush_alu", 128'(alu_sig_o), 128'(5'h1F));
    check("flush_pc", 128'(pc_o), 128'(32'h30));
    set_idle(); tick();

    // LDM first half blocks the interrupt, second half lets it through
    d.st = 1'b1; d.sst = 1'b1; int_req_i = 1'b1; tick();
    check("ldm_busy_int", 128'(interruptSignal_o), 128'(0));
    d.sst = 1'b0; tick();
    check("ldm_done_int", 128'(interruptSignal_o), 128'(1));
    stall_i = 1'b1; #1;
    check("stall_masks_int", 128'(interruptSignal_o), 128'(0));
    stall_i = 1'b0; #1;
    check("unstall_int", 128'(interruptSignal_o), 128'(1));
    int_req_i = 1'b0; d.st = 1'b0;
    d.ftint = FT_FIRST; tick();
    check("int_first_int", 128'(interruptSignal_o), 128'(0));
    d.ftint = FT_SECOND; tick();
    d.ftint = FT_IDLE; tick();
    check("int_cleared", 128'(interruptSignal_o), 128'(0));

    // CALL first phase blocks, second phase presents
    d.ftcall = FT_FIRST; int_req_i = 1'b1; tick();
    check("call_first_int", 128'(interruptSignal_o), 128'(0));
    int_req_i = 1'b0; d.ftcall = FT_SECOND; tick();
    check("call_second_int", 128'(interruptSignal_o), 128'(1));
    d.ftcall = FT_IDLE; d.ftint = FT_FIRST; tick();
    check("call_int_taken", 128'(interruptSignal_o), 128'(0));
    d.ftint = FT_SECOND; tick();
    d.ftint = FT_IDLE; tick();
    check("call_int_clear", 128'(interruptSignal_o), 128'(0));

    // Second request on the INT-start edge stays pending
    int_req_i = 1'b1; tick();
    check("int1_present", 128'(interruptSignal_o), 128'(1));
    int_req_i = 1'b0; tick();
    d.ftint = FT_FIRST; int_req_i = 1'b1; tick();
    check("int2_first", 128'(interruptSignal_o), 128'(0));
    int_req_i = 1'b0; d.ftint = FT_SECOND; tick();
    check("int2_second", 128'(interruptSignal_o), 128'(0));
    d.ftint = FT_IDLE; tick();
    check("int2_reassert", 128'(interruptSignal_o), 128'(1));
    finish_int_seq();
    check("int2_clear", 128'(interruptSignal_o), 128'(0));

    // Flush count holds the interrupt off until it reaches zero
    d.flush_num = 2'd2; int_req_i = 1'b1; tick();
    check("fnum_value", 128'(flush_num_o), 128'(2));
    check("fnum2_int", 128'(interruptSignal_o), 128'(0));
    int_req_i = 1'b0; d.flush_num = 2'd1; tick();
    check("fnum1_int", 128'(interruptSignal_o), 128'(0));
    d.flush_num = 2'd0; tick();
    check("fnum0_int", 128'(interruptSignal_o), 128'(1));
    finish_int_seq();

    // Reset in the middle of a CALL drops the pending interrupt
    d.ftcall = FT_FIRST; int_req_i = 1'b1; tick();
    rst = 1'b1; int_req_i = 1'b0; tick();
    check("rst_mid_ftcall", 128'(ftcall_o), 128'(0));
    rst = 1'b0; d.ftcall = FT_IDLE; tick();
    check("rst_drop_int", 128'(interruptSignal_o), 128'(0));

    // Mixed traffic, checked by the per-cycle model
    for (int i = 0; i < 80; i++) begin
      rv = {$urandom(), $urandom(), $urandom(), $urandom()};
      d = rv[$bits(bundle_t)-1:0];
      stall_i   = ($urandom_range(0, 3) == 0);
      flush_i   = ($urandom_range(0, 5) == 0);
      int_req_i = ($urandom_range(0, 2) == 0);
      tick();
    end

    set_idle(); int_req_i = 1'b0; tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
